// File: rtl/alu_seq_hs_if.sv
// Command/result handshake bundle for alu_seq_hs: command valid/ready in, result valid/ready out.
interface alu_seq_hs_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [3:0]             op;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result;
    logic                   zero;
    logic                   err;
    logic                   busy;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, err, busy
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, err, busy
    );
endinterface

// File: rtl/alu_seq_hs.sv
// Clocked ALU with the classic 16-opcode map: single-cycle logic/add ops,
// iterative shift-add MUL and restoring DIV, valid/ready on both sides.
module alu_seq_hs #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_hs_if.slave hs
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_DEC  = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_DIV  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_INV  = 4'hA;
    localparam logic [3:0] OP_NAND = 4'hB;
    localparam logic [3:0] OP_NOR  = 4'hC;
    localparam logic [3:0] OP_XOR  = 4'hD;
    localparam logic [3:0] OP_XNOR = 4'hE;
    localparam logic [3:0] OP_BUF  = 4'hF;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_q;
    logic               inReady_q;
    logic               outValid_q;
    logic               busy_q;
    logic               zero_q;
    logic               err_q;
    logic [2*WIDTH-1:0] result_q;
    logic [WIDTH-1:0]   workHi_q;
    logic [WIDTH-1:0]   workLo_q;
    logic [WIDTH-1:0]   operand_q;
    logic [CW-1:0]      count_q;

    logic [WIDTH:0]     arith_d;
    logic [2*WIDTH-1:0] simpleRes_d;
    logic [WIDTH:0]     mulSum_d;
    logic [WIDTH-1:0]   mulHi_d;
    logic [WIDTH-1:0]   mulLo_d;
    logic [WIDTH:0]     divShift_d;
    logic [WIDTH:0]     divDiff_d;
    logic               divFits_d;
    logic [WIDTH-1:0]   divHi_d;
    logic [WIDTH-1:0]   divLo_d;
    logic               lastIter_d;

    // Single-cycle ops are evaluated straight off the inputs so the result can be registered on the accept edge.
    always_comb begin
        arith_d = '0;
        case (hs.op)
            OP_ADD:  arith_d = {1'b0, hs.a} + {1'b0, hs.b};
            OP_INC:  arith_d = {1'b0, hs.a} + ONE;
            OP_SUB:  arith_d = {1'b0, hs.a} - {1'b0, hs.b};
            OP_DEC:  arith_d = {1'b0, hs.a} - ONE;
            OP_SHL:  arith_d = {hs.a, 1'b0};
            OP_SHR:  arith_d = {2'b00, hs.a[WIDTH-1:1]};
            OP_AND:  arith_d = {1'b0, hs.a & hs.b};
            OP_OR:   arith_d = {1'b0, hs.a | hs.b};
            OP_INV:  arith_d = {1'b0, ~hs.a};
            OP_NAND: arith_d = {1'b0, ~(hs.a & hs.b)};
            OP_NOR:  arith_d = {1'b0, ~(hs.a | hs.b)};
            OP_XOR:  arith_d = {1'b0, hs.a ^ hs.b};
            OP_XNOR: arith_d = {1'b0, ~(hs.a ^ hs.b)};
            OP_BUF:  arith_d = {1'b0, hs.a};
            default: arith_d = '0;
        endcase
    end

    assign simpleRes_d = {{(WIDTH-1){1'b0}}, arith_d};

    // MUL keeps {partial product, remaining multiplier} in workHi/workLo and shifts right each step.
    assign mulSum_d = {1'b0, workHi_q} + (workLo_q[0] ? {1'b0, operand_q} : '0);
    assign mulHi_d  = mulSum_d[WIDTH:1];
    assign mulLo_d  = {mulSum_d[0], workLo_q[WIDTH-1:1]};

    // DIV keeps {remainder, dividend/quotient}; a clear bit WIDTH of the trial difference means it fits.
    assign divShift_d = {workHi_q, workLo_q[WIDTH-1]};
    assign divDiff_d  = divShift_d - {1'b0, operand_q};
    assign divFits_d  = ~divDiff_d[WIDTH];
    assign divHi_d    = divFits_d ? divDiff_d[WIDTH-1:0] : divShift_d[WIDTH-1:0];
    assign divLo_d    = {workLo_q[WIDTH-2:0], divFits_d};

    assign lastIter_d = (count_q == CW'(WIDTH - 1));

    // Control FSM; every handshake output and flag is a register so the consumer sees glitch-free values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            workHi_q   <= '0;
            workLo_q   <= '0;
            operand_q  <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs.in_valid) begin
                        inReady_q <= 1'b0;
                        err_q     <= 1'b0;
                        count_q   <= '0;
                        workHi_q  <= '0;
                        if (hs.op == OP_MUL) begin
                            state_q   <= MUL;
                            busy_q    <= 1'b1;
                            workLo_q  <= hs.b;
                            operand_q <= hs.a;
                        end else if (hs.op == OP_DIV && hs.b != '0) begin
                            state_q   <= DIV;
                            busy_q    <= 1'b1;
                            workLo_q  <= hs.a;
                            operand_q <= hs.b;
                        end else if (hs.op == OP_DIV) begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                            err_q      <= 1'b1;
                            zero_q     <= 1'b0;
                            result_q   <= {hs.a, {WIDTH{1'b1}}};
                        end else begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                            zero_q     <= (simpleRes_d == '0);
                            result_q   <= simpleRes_d;
                        end
                    end
                end
                MUL: begin
                    workHi_q <= mulHi_d;
                    workLo_q <= mulLo_d;
                    count_q  <= count_q + CW'(1);
                    if (lastIter_d) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        outValid_q <= 1'b1;
                        zero_q     <= ({mulHi_d, mulLo_d} == '0);
                        result_q   <= {mulHi_d, mulLo_d};
                    end
                end
                DIV: begin
                    workHi_q <= divHi_d;
                    workLo_q <= divLo_d;
                    count_q  <= count_q + CW'(1);
                    if (lastIter_d) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        outValid_q <= 1'b1;
                        zero_q     <= ({divHi_d, divLo_d} == '0);
                        result_q   <= {divHi_d, divLo_d};
                    end
                end
                DONE: begin
                    if (hs.out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hs.in_ready  = inReady_q;
    assign hs.out_valid = outValid_q;
    assign hs.busy      = busy_q;
    assign hs.zero      = zero_q;
    assign hs.err       = err_q;
    assign hs.result    = result_q;
endmodule

// File: tb/tb_alu_seq_hs.sv
// Bench for alu_seq_hs: drives an 8-bit and a 16-bit instance with directed and random
// commands and compares every valid result against a plain-arithmetic reference model.
module tb_alu_seq_hs;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_seq_hs_if #(.WIDTH(8))  if8 ();
    alu_seq_hs_if #(.WIDTH(16)) if16 ();

    alu_seq_hs #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .hs(if8.slave));
    alu_seq_hs #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .hs(if16.slave));

    typedef struct packed {
        logic        inReady;
        logic        outValid;
        logic        zero;
        logic        err;
        logic        busy;
        logic [31:0] result;
    } obs_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expRes  [2];
    logic        expErr  [2];
    logic        expZero [2];
    bit          pending [2];

    logic [3:0]  dirOp    [9] = '{4'h0, 4'hD, 4'h4, 4'h5, 4'h5, 4'h2, 4'h3, 4'h6, 4'h0};
    logic [15:0] dirA8    [9] = '{16'hFF, 16'hAA, 16'hFF, 16'd200, 16'h55, 16'h03, 16'h00, 16'h81, 16'h02};
    logic [15:0] dirA16   [9] = '{16'hFFFF, 16'hAAAA, 16'hFFFF, 16'd200, 16'h55, 16'h03, 16'h00, 16'h8001, 16'h02};
    logic [15:0] dirB8    [9] = '{16'h01, 16'hAA, 16'hFF, 16'd7, 16'h00, 16'h05, 16'h00, 16'h00, 16'h03};
    logic [15:0] dirB16   [9] = '{16'h01, 16'hAAAA, 16'hFFFF, 16'd7, 16'h00, 16'h05, 16'h00, 16'h00, 16'h03};
    logic [31:0] dirExp8  [9] = '{32'h100, 32'h0, 32'hFE01, 32'h041C, 32'h55FF, 32'h01FE, 32'h01FF, 32'h0102, 32'h5};
    logic [31:0] dirExp16 [9] = '{32'h10000, 32'h0, 32'hFFFE0001, 32'h0004001C, 32'h0055FFFF, 32'h0001FFFE,
                                  32'h0001FFFF, 32'h00010002, 32'h5};
    logic        dirErr   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        dirZero  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          dirHold  [9] = '{0, 1, 0, 2, 0, 0, 0, 0, 5};

    // Reference: returns {err, result} computed from the opcode rules on plain integers.
    function automatic logic [32:0] refModel(input int w, input logic [3:0] op,
                                             input logic [15:0] ai, input logic [15:0] bi);
        longint unsigned a, b, m, r;
        logic e;
        a = {48'b0, ai};
        b = {48'b0, bi};
        m = (64'd1 << w) - 64'd1;
        e = 1'b0;
        r = 0;
        case (op)
            4'h0: r = a + b;
            4'h1: r = a + 1;
            4'h2: r = ((a - b) & m) | ((a < b) ? (64'd1 << w) : 64'd0);
            4'h3: r = ((a - 1) & m) | ((a == 0) ? (64'd1 << w) : 64'd0);
            4'h4: r = a * b;
            4'h5: begin
                if (b == 0) begin
                    r = (a << w) | m;
                    e = 1'b1;
                end else begin
                    r = ((a % b) << w) | (a / b);
                end
            end
            4'h6: r = a << 1;
            4'h7: r = a >> 1;
            4'h8: r = a & b;
            4'h9: r = a | b;
            4'hA: r = ~a & m;
            4'hB: r = ~(a & b) & m;
            4'hC: r = ~(a | b) & m;
            4'hD: r = a ^ b;
            4'hE: r = ~(a ^ b) & m;
            default: r = a;
        endcase
        return {e, r[31:0]};
    endfunction

    function automatic obs_t observe(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.inReady  = if8.in_ready;
            o.outValid = if8.out_valid;
            o.zero     = if8.zero;
            o.err      = if8.err;
            o.busy     = if8.busy;
            o.result   = {16'b0, if8.result};
        end else begin
            o.inReady  = if16.in_ready;
            o.outValid = if16.out_valid;
            o.zero     = if16.zero;
            o.err      = if16.err;
            o.busy     = if16.busy;
            o.result   = if16.result;
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic v, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] op);
        if (sel == 0) begin
            if8.in_valid = v;
            if8.a        = a[7:0];
            if8.b        = b[7:0];
            if8.op       = op;
        end else begin
            if16.in_valid = v;
            if16.a        = a;
            if16.b        = b;
            if16.op       = op;
        end
    endtask

    task automatic setReady(input int sel, input logic v);
        if (sel == 0) if8.out_ready = v;
        else          if16.out_ready = v;
    endtask

    // One command end to end: accept, wait with a bounded budget, hold, then release.
    task automatic runOp(input int sel, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int hold, output logic [31:0] got, output logic gotErr, output logic gotZero);
        int          w;
        int          lat;
        int          expLat;
        logic [32:0] m;
        obs_t        o;
        w = (sel == 0) ? 8 : 16;
        if (w == 8) begin
            a[15:8] = 8'h00;
            b[15:8] = 8'h00;
        end
        m            = refModel(w, op, a, b);
        expRes[sel]  = m[31:0];
        expErr[sel]  = m[32];
        expZero[sel] = (m[31:0] == 32'd0);
        expLat       = (op == 4'h4 || (op == 4'h5 && b != 16'd0)) ? w + 1 : 1;
        got = '0; gotErr = 1'b0; gotZero = 1'b0;

        o = observe(sel);
        checkOutput("in_ready idle", o.inReady, 1);
        applyStimulus(sel, 1'b1, a, b, op);
        pending[sel] = 1'b1;
        @(posedge clk); #1;
        applyStimulus(sel, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 4'($urandom));
        lat = 1;
        o   = observe(sel);
        while (!o.outValid && lat <= w + 3) begin
            checkOutput("busy while iterating", o.busy, 1);
            checkOutput("in_ready while iterating", o.inReady, 0);
            @(posedge clk); #1;
            lat++;
            o = observe(sel);
        end
        checkOutput("latency", lat, expLat);
        applyStimulus(sel, 1'b0, 16'($urandom), 16'($urandom), 4'($urandom));
        if (!o.outValid) begin
            pending[sel] = 1'b0;
            return;
        end
        got     = o.result;
        gotErr  = o.err;
        gotZero = o.zero;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        setReady(sel, 1'b1);
        @(posedge clk); #1;
        setReady(sel, 1'b0);
        o = observe(sel);
        checkOutput("out_valid after take", o.outValid, 0);
        checkOutput("in_ready after take", o.inReady, 1);
        pending[sel] = 1'b0;
    endtask

    task automatic resetDuringMul(input int sel);
        obs_t        o;
        logic [31:0] got;
        logic        ge;
        logic        gz;
        pending[sel] = 1'b0;
        applyStimulus(sel, 1'b1, 16'h00C3, 16'h005A, 4'h4);
        @(posedge clk); #1;
        applyStimulus(sel, 1'b0, 16'h0, 16'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        o = observe(sel);
        checkOutput("busy before abort", o.busy, 1);
        rst_n = 1'b0;
        #1;
        o = observe(sel);
        checkOutput("abort out_valid", o.outValid, 0);
        checkOutput("abort result", o.result, 0);
        checkOutput("abort in_ready", o.inReady, 1);
        checkOutput("abort busy", o.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        o = observe(sel);
        checkOutput("no result after abort", o.outValid, 0);
        runOp(sel, 4'h0, 16'h2, 16'h3, 0, got, ge, gz);
        checkOutput("add after abort", got, 32'h5);
    endtask

    // Compare process: whenever a result is presented it must match the model and stay stable.
    obs_t mo;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < 2; s++) begin
                mo = observe(s);
                if (mo.outValid) begin
                    if (!pending[s]) begin
                        checkOutput("unexpected out_valid", mo.outValid, 0);
                    end else begin
                        checkOutput("mon result", mo.result, expRes[s]);
                        checkOutput("mon zero", mo.zero, expZero[s]);
                        checkOutput("mon err", mo.err, expErr[s]);
                        checkOutput("mon in_ready in done", mo.inReady, 0);
                        checkOutput("mon busy in done", mo.busy, 0);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] got;
        logic        ge;
        logic        gz;
        logic [15:0] ra;
        logic [15:0] rb;
        obs_t        o;
        rst_n = 1'b0;
        pending[0] = 1'b0;
        pending[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            applyStimulus(s, 1'b0, 16'h0, 16'h0, 4'h0);
            setReady(s, 1'b0);
        end
        #12;
        for (int s = 0; s < 2; s++) begin
            o = observe(s);
            checkOutput("reset in_ready", o.inReady, 1);
            checkOutput("reset out_valid", o.outValid, 0);
            checkOutput("reset result", o.result, 0);
            checkOutput("reset zero", o.zero, 0);
            checkOutput("reset err", o.err, 0);
            checkOutput("reset busy", o.busy, 0);
        end

        checkOutput("model add carry", refModel(8, 4'h0, 16'hFF, 16'h01), 33'h0_0000_0100);
        checkOutput("model mul", refModel(8, 4'h4, 16'hFF, 16'hFF), 33'h0_0000_FE01);
        checkOutput("model div", refModel(8, 4'h5, 16'd200, 16'd7), 33'h0_0000_041C);
        checkOutput("model div0", refModel(8, 4'h5, 16'h55, 16'h0), 33'h1_0000_55FF);
        checkOutput("model sub borrow", refModel(8, 4'h2, 16'h03, 16'h05), 33'h0_0000_01FE);
        checkOutput("model shr", refModel(8, 4'h7, 16'h81, 16'h0), 33'h0_0000_0040);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 9; i++) begin
                runOp(s, dirOp[i], (s == 0) ? dirA8[i] : dirA16[i], (s == 0) ? dirB8[i] : dirB16[i],
                      dirHold[i], got, ge, gz);
                checkOutput("directed result", got, (s == 0) ? dirExp8[i] : dirExp16[i]);
                checkOutput("directed err", ge, dirErr[i]);
                checkOutput("directed zero", gz, dirZero[i]);
            end
            resetDuringMul(s);
            for (int i = 0; i < 40; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                case ($urandom_range(0, 7))
                    0: rb = 16'h0;
                    1: rb = 16'hFFFF;
                    2: ra = 16'h0;
                    default: ;
                endcase
                runOp(s, 4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 3), got, ge, gz);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
